// File: rtl/pocket_pad_conditioner.sv
// rtl/pocket_pad_conditioner.sv - per-pad button debounce, edge pulses and hot-plug clear
// Optional turbo gating built when POCKET_PAD_TURBO_EN is defined.
module pocket_pad_conditioner #(
  parameter int NUM_PADS       = 4,
  parameter int NUM_BUTTONS    = 16,
  parameter int DEBOUNCE_TICKS = 8,
  parameter int TURBO_TICKS    = 32
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            tick_i,
  input  logic [NUM_PADS*32-1:0]          key_i,
  input  logic [NUM_PADS*NUM_BUTTONS-1:0] turbo_mask_i,
  output logic [NUM_PADS*32-1:0]          key_o,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] press_o,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] release_o,
  output logic [NUM_PADS-1:0]             changed_o
);

  localparam int CW = (DEBOUNCE_TICKS < 1) ? 1 : $clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_TICKS < 1) ? '0 : CW'(DEBOUNCE_TICKS - 1);

  typedef logic [NUM_BUTTONS-1:0] btn_t;

  logic [NUM_PADS-1:0][3:0]                   r_type;
  btn_t [NUM_PADS-1:0]                        r_stable;
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0][CW-1:0] r_cnt;
  btn_t [NUM_PADS-1:0]                        r_press;
  btn_t [NUM_PADS-1:0]                        r_release;
  logic [NUM_PADS-1:0]                        r_changed;

  logic [NUM_PADS-1:0][3:0]                   w_type_in;
  logic [NUM_PADS-1:0]                        w_hot;
  btn_t [NUM_PADS-1:0]                        w_raw;
  btn_t [NUM_PADS-1:0]                        w_stable_nxt;
  logic [NUM_PADS-1:0][NUM_BUTTONS-1:0][CW-1:0] w_cnt_nxt;
  btn_t [NUM_PADS-1:0]                        w_press;
  btn_t [NUM_PADS-1:0]                        w_release;
  logic [NUM_PADS-1:0]                        w_changed;
  btn_t [NUM_PADS-1:0]                        w_btn;
  logic                                       w_unused_key;

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      w_type_in[p] = key_i[32*p+28 +: 4];
      w_raw[p]     = key_i[32*p +: NUM_BUTTONS];
      w_hot[p]     = (w_type_in[p] != r_type[p]);
    end
  end

  always_comb begin
    w_unused_key = 1'b0;
    for (int p = 0; p < NUM_PADS; p++) begin
      w_unused_key = w_unused_key ^ (^key_i[32*p+NUM_BUTTONS +: 28-NUM_BUTTONS]);
    end
  end

  // A type change or an absent controller forces the pad back to all-released.
  always_comb begin
    w_stable_nxt = r_stable;
    w_cnt_nxt    = r_cnt;
    w_press      = '0;
    w_release    = '0;
    w_changed    = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      for (int b = 0; b < NUM_BUTTONS; b++) begin
        if (w_hot[p] || (r_type[p] == 4'd0)) begin
          w_stable_nxt[p][b] = 1'b0;
          w_cnt_nxt[p][b]    = '0;
        end else if (DEBOUNCE_TICKS == 0) begin
          w_stable_nxt[p][b] = w_raw[p][b];
          w_cnt_nxt[p][b]    = '0;
        end else if (w_raw[p][b] == r_stable[p][b]) begin
          w_cnt_nxt[p][b] = '0;
        end else if (tick_i) begin
          if (r_cnt[p][b] == CNT_LAST) begin
            w_stable_nxt[p][b] = w_raw[p][b];
            w_cnt_nxt[p][b]    = '0;
          end else begin
            w_cnt_nxt[p][b] = r_cnt[p][b] + CW'(1);
          end
        end
      end
      w_press[p]   = w_stable_nxt[p] & ~r_stable[p] & ~{NUM_BUTTONS{w_hot[p]}};
      w_release[p] = ~w_stable_nxt[p] & r_stable[p] & ~{NUM_BUTTONS{w_hot[p]}};
      w_changed[p] = |(w_press[p] | w_release[p]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type    <= '0;
      r_stable  <= '0;
      r_cnt     <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_changed <= '0;
    end else begin
      r_type    <= w_type_in;
      r_stable  <= w_stable_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press;
      r_release <= w_release;
      r_changed <= w_changed;
    end
  end

`ifdef POCKET_PAD_TURBO_EN
  localparam int TW = (TURBO_TICKS <= 1) ? 1 : $clog2(TURBO_TICKS);
  localparam logic [TW-1:0] TCNT_LAST = TW'(TURBO_TICKS - 1);

  logic [NUM_PADS-1:0]          r_phase;
  logic [NUM_PADS-1:0][TW-1:0]  r_tcnt;
  btn_t [NUM_PADS-1:0]          w_mask;

  always_comb begin
    for (int p = 0; p < NUM_PADS; p++) begin
      w_mask[p] = turbo_mask_i[p*NUM_BUTTONS +: NUM_BUTTONS];
      w_btn[p]  = r_stable[p] & (~w_mask[p] | {NUM_BUTTONS{r_phase[p]}});
    end
  end

  // A fresh press on a gated button restarts the phase so it is seen high at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_phase <= '1;
      r_tcnt  <= '0;
    end else begin
      for (int p = 0; p < NUM_PADS; p++) begin
        if (w_hot[p] || (|(w_press[p] & w_mask[p]))) begin
          r_phase[p] <= 1'b1;
          r_tcnt[p]  <= '0;
        end else if (tick_i) begin
          if (r_tcnt[p] == TCNT_LAST) begin
            r_phase[p] <= ~r_phase[p];
            r_tcnt[p]  <= '0;
          end else begin
            r_tcnt[p] <= r_tcnt[p] + TW'(1);
          end
        end
      end
    end
  end
`else
  logic w_unused_mask;

  assign w_unused_mask = ^turbo_mask_i;

  always_comb begin
    w_btn = r_stable;
  end
`endif

  always_comb begin
    key_o = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      key_o[32*p+28 +: 4]         = r_type[p];
      key_o[32*p +: NUM_BUTTONS]  = w_btn[p];
    end
  end

  assign press_o   = r_press;
  assign release_o = r_release;
  assign changed_o = r_changed;

endmodule

// File: tb/tb_pocket_pad_conditioner.sv
// tb/tb_pocket_pad_conditioner.sv - scoreboard bench for pocket_pad_conditioner
// Expectations for turbo gating follow POCKET_PAD_TURBO_EN.
module tb_pocket_pad_conditioner;

  localparam int NP = 4;
  localparam int NB = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            tick_i;
  logic [NP*32-1:0] key_i;
  logic [NP*NB-1:0] turbo_mask_i;
  logic [NP*32-1:0] key_o;
  logic [NP*NB-1:0] press_o;
  logic [NP*NB-1:0] release_o;
  logic [NP-1:0]    changed_o;

  int n_err = 0;
  int n_chk = 0;

  typedef struct {
    int          pad;
    logic [31:0] key;
    logic [63:0] press;
    logic [63:0] rel;
    logic [3:0]  chg;
  } ev_t;

  ev_t q[$];
  ev_t mon_e;

  pocket_pad_conditioner #(
    .NUM_PADS(NP),
    .NUM_BUTTONS(NB),
    .DEBOUNCE_TICKS(8),
    .TURBO_TICKS(4)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .tick_i(tick_i),
    .key_i(key_i),
    .turbo_mask_i(turbo_mask_i),
    .key_o(key_o),
    .press_o(press_o),
    .release_o(release_o),
    .changed_o(changed_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_ev(input int p, input logic [31:0] k, input logic [63:0] pr,
                         input logic [63:0] rl, input logic [3:0] cg);
    ev_t e;
    e.pad = p; e.key = k; e.press = pr; e.rel = rl; e.chg = cg;
    q.push_back(e);
  endtask

  task automatic step(input logic t);
    tick_i = t;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
  endtask

  task automatic set_pad(input int p, input logic [31:0] v);
    key_i[32*p +: 32] = v;
  endtask

  function automatic logic [31:0] pad_key(input int p);
    return key_o[32*p +: 32];
  endfunction

  // Eight ticks with idle cycles between; the eighth accepts the change.
  task automatic debounce(input int p, input logic [31:0] old_key, input logic [31:0] new_key,
                          input logic [63:0] pr, input logic [63:0] rl);
    for (int i = 1; i <= 8; i++) begin
      if (i == 8) push_ev(p, new_key, pr, rl, 4'(1 << p));
      step(1'b1);
      if (i == 7) chk("pre_accept", pad_key(p), old_key);
      step(1'b0);
    end
    chk("post_accept", pad_key(p), new_key);
  endtask

  always @(negedge clk) begin
    if (reset_n && ((|changed_o) || (|press_o) || (|release_o))) begin
      if (q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL unexpected_pulse: press=%h release=%h changed=%h expected none",
                 press_o, release_o, changed_o);
      end else begin
        mon_e = q.pop_front();
        chk("press_o", press_o, mon_e.press);
        chk("release_o", release_o, mon_e.rel);
        chk("changed_o", changed_o, mon_e.chg);
        chk("event_key", key_o[32*mon_e.pad +: 32], mon_e.key);
      end
    end
  end

  initial begin
    logic [31:0] exp_k;
    logic        hi;
    reset_n      = 1'b0;
    tick_i       = 1'b0;
    key_i        = '1;
    turbo_mask_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_key", key_o, '0);
    chk("reset_press", press_o, '0);
    chk("reset_release", release_o, '0);
    chk("reset_changed", changed_o, '0);

    key_i = '0;
    set_pad(0, 32'h1000_0001);
    reset_n = 1'b1;
    step(1'b0);
    chk("type_after_reset", pad_key(0), 32'h1000_0000);
    debounce(0, 32'h1000_0000, 32'h1000_0001, 64'h1, 64'h0);
    step(1'b0);

    set_pad(3, 32'h1000_0000);
    step(1'b0);
    chk("glitch_type", pad_key(3), 32'h1000_0000);
    set_pad(3, 32'h1000_0001);
    for (int i = 0; i < 7; i++) begin
      step(1'b1);
      step(1'b0);
    end
    chk("glitch_7ticks", pad_key(3), 32'h1000_0000);
    set_pad(3, 32'h1000_0000);
    for (int i = 0; i < 10; i++) begin
      step(1'b1);
      step(1'b0);
    end
    chk("glitch_after", pad_key(3), 32'h1000_0000);

    set_pad(1, 32'h1000_0010);
    step(1'b0);
    debounce(1, 32'h1000_0000, 32'h1000_0010, 64'h1 << 20, 64'h0);
    set_pad(1, 32'h3000_0010);
    step(1'b0);
    chk("hotplug_key", pad_key(1), 32'h3000_0000);
    set_pad(1, 32'h3000_0000);
    repeat (3) step(1'b1);
    chk("hotplug_hold", pad_key(1), 32'h3000_0000);

    set_pad(2, 32'h1000_0020);
    step(1'b0);
    debounce(2, 32'h1000_0000, 32'h1000_0020, 64'h1 << 37, 64'h0);
    set_pad(2, 32'h1000_0040);
    debounce(2, 32'h1000_0020, 32'h1000_0040, 64'h1 << 38, 64'h1 << 37);

    turbo_mask_i[4] = 1'b1;
    set_pad(0, 32'h1000_0011);
    debounce(0, 32'h1000_0001, 32'h1000_0011, 64'h10, 64'h0);
    for (int k = 1; k <= 12; k++) begin
      step(1'b1);
`ifdef POCKET_PAD_TURBO_EN
      hi = ((k / 4) % 2 == 0);
`else
      hi = 1'b1;
`endif
      exp_k = hi ? 32'h1000_0011 : 32'h1000_0001;
      chk("turbo_key", pad_key(0), exp_k);
      step(1'b0);
    end

    set_pad(2, 32'h1000_00C0);
    repeat (3) begin
      step(1'b1);
      step(1'b0);
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_key", key_o, '0);
    chk("async_reset_press", press_o, '0);
    key_i = '0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (4) step(1'b1);
    chk("post_reset_key", key_o, '0);
    chk("queue_empty", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pocket_pad_conditioner.md
# pocket_pad_conditioner

- Multi-pad input conditioner between the APF controller words (one `key_t`-format word per pad) and core logic.
- Per button, per pad:
  - debounce against a tick strobe;
  - produce one-cycle press and release pulses;
  - drop all state on controller hot-plug or type change.
- Optional per-button turbo gating.
- Parametrised generalisation of the fixed single-word key decode.
- Feeds core input logic and the menu and OSD navigation.

## Interface
Parameters:
- `NUM_PADS`, 4: number of controller words handled.
- `NUM_BUTTONS`, 16: button bits per word, taken from bit 0 upward (max 16).
- `DEBOUNCE_TICKS`, 8: ticks a raw change must persist before it is accepted. 0 means registered pass-through.
- `TURBO_TICKS`, 32: turbo half-period in ticks, ≥1. Used only with the turbo macro.

Ports:
- `clk`, in, 1: single core clock.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `tick_i`, in, 1: one-cycle sample strobe, e.g. 1 kHz.
- `key_i`, in, `NUM_PADS*32`: raw key words, pad p at `[32p+31:32p]`. Already synchronous to `clk`.
- `turbo_mask_i`, in, `NUM_PADS*NUM_BUTTONS`: 1 means the button is turbo-gated.
- `key_o`, out, `NUM_PADS*32`: conditioned key words, same layout.
- `press_o`, out, `NUM_PADS*NUM_BUTTONS`: one-cycle pulse when the debounced button goes 0→1.
- `release_o`, out, `NUM_PADS*NUM_BUTTONS`: one-cycle pulse when the debounced button goes 1→0.
- `changed_o`, out, `NUM_PADS`: one-cycle pulse on any press or release for that pad.

## Operation
- Per button state:
  - `stable` bit;
  - counter of width `$clog2(DEBOUNCE_TICKS+1)`.
- Any cycle with raw == `stable`: counter ← 0.
- Raw != `stable` and `tick_i`:
  - counter increments.
  - When counter == `DEBOUNCE_TICKS-1`: `stable` ← raw and counter ← 0.
- `DEBOUNCE_TICKS`=0: `stable` ← raw every cycle; tick is ignored.
- Counter never wraps. A glitch shorter than `DEBOUNCE_TICKS` ticks is discarded.
- `key_o` fields:
  - `[31:28]` = registered `controller_type`.
  - `[27:NUM_BUTTONS]` = 0.
  - Button bits = `stable`, turbo-gated if the macro is enabled.
- Hot-plug: when the registered type differs from the incoming type, at that edge:
  - that pad's `stable` bits and counters clear to 0;
  - the type register updates;
  - press and release pulses are suppressed for that cycle.
- Type `controller_none` (0): button bits are held at 0 regardless of raw input. Counters stay 0.
- `press_o` and `release_o` reflect debounced `stable` only, never turbo gating.
- Pads are fully independent. A simultaneous press on one button and release on another both pulse in the same cycle.

## Timing
- Reset values:
  - `key_o` all 0 (every pad reads `controller_none`);
  - `press_o`, `release_o`, `changed_o` all 0;
  - counters 0;
  - turbo phase 1.
- `stable`, `key_o`, `press_o` and `release_o` all update on the same edge.
- A pulse is high only in the first cycle that `key_o` shows the new value.
- `changed_o` = registered OR of that pad's press and release terms. It is coincident with the pulses.
- Latency of a change already held steady (`DEBOUNCE_TICKS`≥1):
  - `key_o` changes at the edge that samples the `DEBOUNCE_TICKS`-th asserted `tick_i` counted from the first mismatching cycle;
  - a tick in that first mismatching cycle counts.
- Latency with `DEBOUNCE_TICKS`=0: one clock.
- Type-change latency: one clock.
- `reset_n` asserted mid-debounce: all state clears immediately and asynchronously. No pulse is emitted on reset release.

## Configuration
- Macro `POCKET_PAD_TURBO_EN`.
- Defined:
  - Each pad has a tick counter, width `$clog2(TURBO_TICKS)`, and a phase bit.
  - Phase toggles every `TURBO_TICKS` ticks.
  - Phase ← 1 and counter ← 0 whenever any masked button of that pad produces `press_o`.
  - Masked button bits in `key_o` = `stable` & phase.
  - Type change resets that pad's phase to 1.
- Undefined:
  - `turbo_mask_i` is present and ignored.
  - No turbo logic is built.
  - Button bits = `stable`.

## Test plan
- **Reset:** hold `reset_n`=0, drive `key_i`=all 1s → `key_o`=0, no pulses. Release reset with `key_i` pad 0 = 0x1000_0001, `DEBOUNCE_TICKS`=8 → type reads 1 after one clock; bit 0 rises at the 8th tick; `press_o[0]` and `changed_o[0]` pulse for exactly one cycle.
- **Glitch rejection:** with type 1, raise `dpad_up` for 7 ticks, then drop it → `key_o` bit 0 never rises; no pulses.
- **Hot-plug:** pad 1 type 1 with `face_a` debounced high; change type to 3 → next edge `key_o` pad 1 = 0x3000_0000; `release_o` stays 0.
- **Simultaneous events:** pad 2 debounced with `face_b`=1; raw `face_b`→0 and `face_x`→1 in the same cycle → `release_o` bit 5 and `press_o` bit 6 pulse in the same cycle; `changed_o[2]` pulses once.
- **Turbo (`POCKET_PAD_TURBO_EN`, `TURBO_TICKS`=4):** mask pad 0 bit 4 and hold it pressed → `key_o` bit 4 alternates 4 ticks high, 4 ticks low; `press_o` bit 4 pulses once. Without the macro → bit 4 holds high.
